// File: rtl/pipe_stage_4_mode_ctrl_pkg.sv
// rtl/pipe_stage_4_mode_ctrl_pkg.sv - shared types, widths and bound helper for the stage-4 mode controller
// Provides: DATA_W/CNT_W/NUM_MODES/MODE_W widths, mode_t, fsm_state_t,
// bounds_t and calc_bounds() which derives a saturated [lb,ub] around a window max.
package pipe_stage_4_mode_ctrl_pkg;

   localparam int DATA_W    = 16;
   localparam int CNT_W     = 8;
   localparam int NUM_MODES = 4;
   localparam int MODE_W    = 2;

   typedef enum logic [MODE_W-1:0] {MODE0, MODE1, MODE2, MODE3} mode_t;

   typedef enum logic [1:0] {ACCUM, DECIDE, RECONFIG} fsm_state_t;

   typedef struct packed {
      logic [DATA_W-1:0] lb;
      logic [DATA_W-1:0] ub;
   } bounds_t;

   // One extra bit of headroom so the upper bound can be clamped instead of wrapping.
   function automatic bounds_t calc_bounds(input logic [DATA_W-1:0] win_max,
                                           input int unsigned        shift);
      logic [DATA_W:0] wide;
      logic [DATA_W:0] margin;
      logic [DATA_W:0] lo;
      logic [DATA_W:0] hi;
      bounds_t         b;
      wide   = {1'b0, win_max};
      margin = wide >> shift;
      lo     = wide - margin;
      hi     = wide + margin;
      b.lb   = lo[DATA_W-1:0];
      b.ub   = hi[DATA_W] ? '1 : hi[DATA_W-1:0];
      return b;
   endfunction

endpackage

// File: rtl/pipe_stage_4_mode_ctrl_if.sv
// rtl/pipe_stage_4_mode_ctrl_if.sv - stage-3 / reconfig-tile bundle seen by the stage-4 controller
// master: stage 3 and tile side (drives samples and ack); slave: the controller.
import pipe_stage_4_mode_ctrl_pkg::*;

interface pipe_stage_4_mode_ctrl_if;
   logic              valid_i;
   logic              stall_i;
   logic [DATA_W-1:0] max_score_i;
   logic              out_of_mode_interval_i;
   logic [CNT_W-1:0]  interval_cnt_i;
   logic [DATA_W-1:0] interval_lb_o;
   logic [DATA_W-1:0] interval_ub_o;
   logic [MODE_W-1:0] mode_o;
   logic              reconfig_req_o;
   logic              reconfig_ack_i;
   logic              stall_o;
   logic              window_done_o;
   logic              cnt_err_o;

   modport master (
      output valid_i, stall_i, max_score_i, out_of_mode_interval_i, interval_cnt_i, reconfig_ack_i,
      input  interval_lb_o, interval_ub_o, mode_o, reconfig_req_o, stall_o, window_done_o, cnt_err_o
   );

   modport slave (
      input  valid_i, stall_i, max_score_i, out_of_mode_interval_i, interval_cnt_i, reconfig_ack_i,
      output interval_lb_o, interval_ub_o, mode_o, reconfig_req_o, stall_o, window_done_o, cnt_err_o
   );
endinterface

// File: rtl/pipe_stage_4_mode_ctrl_window_accum.sv
// rtl/pipe_stage_4_mode_ctrl_window_accum.sv - per-window sample count, out-of-interval count and max score
// Ports: clk/rst, clear (zero all), accept (take one sample), oob_flag, score;
// outputs sample_cnt, oob_cnt (saturating), win_max.
import pipe_stage_4_mode_ctrl_pkg::*;

module pipe_stage_4_mode_ctrl_window_accum (
   input  logic              clk,
   input  logic              rst,
   input  logic              clear,
   input  logic              accept,
   input  logic              oob_flag,
   input  logic [DATA_W-1:0] score,
   output logic [CNT_W-1:0]  sample_cnt,
   output logic [CNT_W-1:0]  oob_cnt,
   output logic [DATA_W-1:0] win_max
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sample_cnt <= '0;
         oob_cnt    <= '0;
         win_max    <= '0;
      end else if (clear) begin
         sample_cnt <= '0;
         oob_cnt    <= '0;
         win_max    <= '0;
      end else if (accept) begin
         sample_cnt <= sample_cnt + 1'b1;
         if (oob_flag && (oob_cnt != '1))
            oob_cnt <= oob_cnt + 1'b1;
         if (score > win_max)
            win_max <= score;
      end
   end

endmodule

// File: rtl/pipe_stage_4_mode_ctrl.sv
// rtl/pipe_stage_4_mode_ctrl.sv - windowed mode/interval decision with req/ack tile reconfiguration
// Ports: CLK_i, RST_i (async, active high), bus (slave modport): stage-3 samples in,
// interval bounds and mode out, reconfig req/ack, stall_o, window_done_o, cnt_err_o.
import pipe_stage_4_mode_ctrl_pkg::*;

module pipe_stage_4_mode_ctrl #(
   parameter int          WINDOW       = 64,
   parameter int          THRESH       = 8,
   parameter int unsigned MARGIN_SHIFT = 2
) (
   input logic                     CLK_i,
   input logic                     RST_i,
   pipe_stage_4_mode_ctrl_if.slave bus
);

   localparam logic [CNT_W:0]    WINDOW_W = (CNT_W+1)'(WINDOW);
   localparam logic [CNT_W-1:0]  LAST_IDX = CNT_W'(WINDOW - 1);
   localparam logic [CNT_W-1:0]  THRESH_C = CNT_W'(THRESH);
   localparam logic [MODE_W-1:0] TOP_MODE = MODE_W'(NUM_MODES - 1);

   fsm_state_t        state_q, state_d;
   mode_t             mode_q, tgt_q, tgt_d;
   logic [DATA_W-1:0] lb_q, ub_q, pend_lb_q, pend_ub_q;
   logic              err_q;

   logic              accept;
   logic              load_direct;
   logic              start_rc;
   logic [CNT_W-1:0]  sample_cnt, oob_cnt;
   logic [DATA_W-1:0] win_max;
   logic [CNT_W:0]    cnt_sum;
   logic [MODE_W-1:0] mode_bits;
   bounds_t           new_b;

   assign accept = bus.valid_i && !bus.stall_i && (state_q == ACCUM);

   pipe_stage_4_mode_ctrl_window_accum u_accum (
      .clk        (CLK_i),
      .rst        (RST_i),
      .clear      (state_q == DECIDE),
      .accept     (accept),
      .oob_flag   (bus.out_of_mode_interval_i),
      .score      (bus.max_score_i),
      .sample_cnt (sample_cnt),
      .oob_cnt    (oob_cnt),
      .win_max    (win_max)
   );

   // Full-width sum: a WINDOW of 2**CNT_W does not fit in CNT_W bits.
   assign cnt_sum   = {1'b0, bus.interval_cnt_i} + {1'b0, oob_cnt};
   assign new_b     = calc_bounds(win_max, MARGIN_SHIFT);
   assign mode_bits = mode_q;

   always_comb begin
      state_d     = state_q;
      load_direct = 1'b0;
      start_rc    = 1'b0;
      tgt_d       = mode_q;

      // Step one mode toward where the window max landed relative to the current interval.
      if (win_max > ub_q)
         tgt_d = (mode_bits == TOP_MODE) ? mode_q : mode_t'(mode_bits + 1'b1);
      else if (win_max < lb_q)
         tgt_d = (mode_bits == '0) ? mode_q : mode_t'(mode_bits - 1'b1);

      case (state_q)
         ACCUM: begin
            if (accept && (sample_cnt == LAST_IDX))
               state_d = DECIDE;
         end
         DECIDE: begin
            state_d = ACCUM;
            if (oob_cnt > THRESH_C) begin
               if (tgt_d == mode_q) begin
                  load_direct = 1'b1;
               end else begin
                  start_rc = 1'b1;
                  state_d  = RECONFIG;
               end
            end
         end
         RECONFIG: begin
            if (bus.reconfig_ack_i)
               state_d = ACCUM;
         end
         default: state_d = ACCUM;
      endcase
   end

   always_ff @(posedge CLK_i or posedge RST_i) begin
      if (RST_i) begin
         state_q   <= ACCUM;
         mode_q    <= MODE0;
         tgt_q     <= MODE0;
         lb_q      <= '0;
         ub_q      <= '1;
         pend_lb_q <= '0;
         pend_ub_q <= '0;
         err_q     <= 1'b0;
      end else begin
         state_q <= state_d;
         if ((state_q == DECIDE) && (cnt_sum != WINDOW_W))
            err_q <= 1'b1;
         if (load_direct) begin
            lb_q <= new_b.lb;
            ub_q <= new_b.ub;
         end
         if (start_rc) begin
            tgt_q     <= tgt_d;
            pend_lb_q <= new_b.lb;
            pend_ub_q <= new_b.ub;
         end
         if ((state_q == RECONFIG) && bus.reconfig_ack_i) begin
            mode_q <= tgt_q;
            lb_q   <= pend_lb_q;
            ub_q   <= pend_ub_q;
         end
      end
   end

   // Request is a decode of the registered state, so reset removes it without waiting for a clock.
   assign bus.reconfig_req_o = (state_q == RECONFIG);
   assign bus.stall_o        = (state_q != ACCUM);
   assign bus.window_done_o  = (state_q == DECIDE);
   assign bus.cnt_err_o      = err_q;
   assign bus.interval_lb_o  = lb_q;
   assign bus.interval_ub_o  = ub_q;
   assign bus.mode_o         = mode_q;

endmodule

// File: tb/tb_pipe_stage_4_mode_ctrl.sv
// tb/tb_pipe_stage_4_mode_ctrl.sv - self-checking bench for pipe_stage_4_mode_ctrl
module tb_pipe_stage_4_mode_ctrl;

   localparam int WIN = 8;
   localparam int THR = 2;

   logic clk;
   logic rst;
   int   n_checks;
   int   n_fail;

   int   m_mode, m_lb, m_ub;
   bit   m_err;

   pipe_stage_4_mode_ctrl_if bus ();

   pipe_stage_4_mode_ctrl #(
      .WINDOW       (WIN),
      .THRESH       (THR),
      .MARGIN_SHIFT (2)
   ) dut (
      .CLK_i (clk),
      .RST_i (rst),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] max;
      int          n_oob;
      logic [7:0]  icnt;
      int          ack_dly;
      int          e_mode;
      int          e_lb;
      int          e_ub;
      bit          e_err;
      bit          e_req;
   } vec_t;

   vec_t tbl[12];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic model_reset();
      m_mode = 0;
      m_lb   = 0;
      m_ub   = 65535;
      m_err  = 0;
   endtask

   // Window decision from the rules: margin = max/4, upper bound clamped to 16 bits.
   task automatic model_decide(input int wmax, input int n, input int icnt,
                               output bit want_req, output int tgt, output int nlb, output int nub);
      int margin;
      if (icnt + n != WIN) m_err = 1;
      margin   = wmax / 4;
      nlb      = wmax - margin;
      nub      = wmax + margin;
      if (nub > 65535) nub = 65535;
      want_req = 0;
      tgt      = m_mode;
      if (n > THR) begin
         if (wmax > m_ub)      tgt = (m_mode < 3) ? m_mode + 1 : 3;
         else if (wmax < m_lb) tgt = (m_mode > 0) ? m_mode - 1 : 0;
         if (tgt == m_mode) begin
            m_lb = nlb;
            m_ub = nub;
         end else begin
            want_req = 1;
         end
      end
   endtask

   task automatic check_model(input string tag);
      check({tag, "_mode"}, 32'(bus.mode_o), 32'(m_mode));
      check({tag, "_lb"}, 32'(bus.interval_lb_o), 32'(m_lb));
      check({tag, "_ub"}, 32'(bus.interval_ub_o), 32'(m_ub));
      check({tag, "_err"}, 32'(bus.cnt_err_o), 32'(m_err));
   endtask

   task automatic do_reset();
      rst = 1'b1;
      bus.valid_i = 0;
      bus.stall_i = 0;
      bus.max_score_i = '0;
      bus.out_of_mode_interval_i = 0;
      bus.interval_cnt_i = '0;
      bus.reconfig_ack_i = 0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      model_reset();
   endtask

   // ack_dly < 0 leaves the controller waiting in reconfiguration.
   task automatic run_window(input logic [7:0][15:0] sc, input logic [7:0] mask, input logic [7:0] icnt,
                             input int ack_dly, input bit gaps, input bit stall_rc, output bit saw_req);
      int  k, guard, wmax, n, tgt, nlb, nub;
      bit  acc, early, want_req;
      k = 0; guard = 0; early = 0; wmax = 0; n = 0;
      for (int j = 0; j < WIN; j++) begin
         if (int'(sc[j]) > wmax) wmax = int'(sc[j]);
         n += int'(mask[j]);
      end
      bus.interval_cnt_i = icnt;
      while (k < WIN && guard < 400) begin
         bus.valid_i = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
         bus.stall_i = gaps ? ($urandom_range(0, 4) == 0) : 1'b0;
         bus.max_score_i = sc[k];
         bus.out_of_mode_interval_i = mask[k];
         @(negedge clk);
         if (bus.window_done_o) early = 1;
         acc = bus.valid_i && !bus.stall_i && !bus.stall_o;
         @(posedge clk); #1;
         if (acc) k++;
         guard++;
      end
      bus.valid_i = 0;
      bus.stall_i = 0;
      check("accept_budget", 32'(k), 32'(WIN));
      check("done_early", 32'(early), 0);
      check("done_pulse", 32'(bus.window_done_o), 1);
      check("decide_stall", 32'(bus.stall_o), 1);
      model_decide(wmax, n, int'(icnt), want_req, tgt, nlb, nub);
      @(posedge clk); #1;
      check("done_single", 32'(bus.window_done_o), 0);
      check("req", 32'(bus.reconfig_req_o), 32'(want_req));
      saw_req = bus.reconfig_req_o;
      if (want_req && ack_dly >= 0) begin
         repeat (ack_dly) @(posedge clk);
         #1 check("req_hold", 32'(bus.reconfig_req_o), 1);
         check("rc_mode_held", 32'(bus.mode_o), 32'(m_mode));
         bus.reconfig_ack_i = 1;
         bus.stall_i = stall_rc;
         @(posedge clk); #1;
         bus.reconfig_ack_i = 0;
         bus.stall_i = 0;
         m_mode = tgt; m_lb = nlb; m_ub = nub;
         check("req_drop", 32'(bus.reconfig_req_o), 0);
      end
      if (!(want_req && ack_dly < 0)) begin
         check("stall_release", 32'(bus.stall_o), 0);
         check_model("win");
      end
   endtask

   task automatic table_window(input vec_t v, input bit stall_rc, output bit saw_req);
      logic [7:0][15:0] sc;
      logic [7:0]       mask;
      for (int j = 0; j < WIN; j++) sc[j] = (j == 3) ? v.max : (v.max >> 1);
      mask = 8'((32'h1 << v.n_oob) - 1);
      run_window(sc, mask, v.icnt, v.ack_dly, 1'b0, stall_rc, saw_req);
   endtask

   initial begin
      logic [7:0][15:0] sc;
      logic [7:0]       mask;
      bit               sr, early;
      int               pc;
      n_checks = 0;
      n_fail   = 0;

      tbl[0]  = '{16'd100,    0, 8'd8, 0, 0, 0,      65535,  0, 0};
      tbl[1]  = '{16'd160,    3, 8'd5, 0, 0, 120,    200,    0, 0};
      tbl[2]  = '{16'd400,    3, 8'd5, 3, 1, 300,    500,    0, 1};
      tbl[3]  = '{16'd400,    3, 8'd5, 0, 1, 300,    500,    0, 0};
      tbl[4]  = '{16'd1000,   4, 8'd4, 0, 2, 750,    1250,   0, 1};
      tbl[5]  = '{16'd2000,   8, 8'd0, 1, 3, 1500,   2500,   0, 1};
      tbl[6]  = '{16'd4000,   3, 8'd5, 0, 3, 3000,   5000,   0, 0};
      tbl[7]  = '{16'hF000,   3, 8'd5, 0, 3, 'hB400, 'hFFFF, 0, 0};
      tbl[8]  = '{16'd100,    3, 8'd5, 2, 2, 75,     125,    0, 1};
      tbl[9]  = '{16'd100,    2, 8'd6, 0, 2, 75,     125,    0, 0};
      tbl[10] = '{16'd50,     3, 8'd5, 1, 1, 38,     62,     0, 1};
      tbl[11] = '{16'd50,     0, 8'd7, 0, 1, 38,     62,     1, 0};

      do_reset();
      check("rst_lb", 32'(bus.interval_lb_o), 0);
      check("rst_ub", 32'(bus.interval_ub_o), 32'hFFFF);
      check("rst_mode", 32'(bus.mode_o), 0);
      check("rst_req", 32'(bus.reconfig_req_o), 0);
      check("rst_stall", 32'(bus.stall_o), 0);
      check("rst_done", 32'(bus.window_done_o), 0);
      check("rst_err", 32'(bus.cnt_err_o), 0);

      for (int i = 0; i < 12; i++) begin
         table_window(tbl[i], 1'(i % 2), sr);
         check("tbl_req", 32'(sr), 32'(tbl[i].e_req));
         check("tbl_mode", 32'(bus.mode_o), 32'(tbl[i].e_mode));
         check("tbl_lb", 32'(bus.interval_lb_o), 32'(tbl[i].e_lb));
         check("tbl_ub", 32'(bus.interval_ub_o), 32'(tbl[i].e_ub));
         check("tbl_err", 32'(bus.cnt_err_o), 32'(tbl[i].e_err));
         if (i == 7) begin
            bus.reconfig_ack_i = 1;
            repeat (2) @(posedge clk);
            #1 bus.reconfig_ack_i = 0;
            @(posedge clk); #1;
            check("stray_ack_req", 32'(bus.reconfig_req_o), 0);
            check_model("stray_ack");
         end
      end

      // Stall freezes acceptance, including on the window's final sample.
      do_reset();
      early = 0;
      bus.interval_cnt_i = 8'd7;
      bus.max_score_i = 16'd100;
      bus.out_of_mode_interval_i = 0;
      bus.valid_i = 1;
      repeat (7) begin
         @(posedge clk); #1;
         if (bus.window_done_o) early = 1;
      end
      bus.stall_i = 1;
      repeat (5) begin
         @(posedge clk); #1;
         if (bus.window_done_o) early = 1;
      end
      check("stall_no_done", 32'(early), 0);
      bus.stall_i = 0;
      @(posedge clk); #1;
      bus.valid_i = 0;
      check("stall_window_end", 32'(bus.window_done_o), 1);
      @(posedge clk); #1;
      check("cnt_err_set", 32'(bus.cnt_err_o), 1);
      check("cnt_err_noreq", 32'(bus.reconfig_req_o), 0);
      m_err = 1;
      for (int j = 0; j < WIN; j++) sc[j] = 16'd100;
      run_window(sc, 8'h00, 8'd8, 0, 1'b0, 1'b0, sr);
      check("cnt_err_sticky", 32'(bus.cnt_err_o), 1);

      // Reset while a reconfiguration request is outstanding.
      do_reset();
      for (int j = 0; j < WIN; j++) sc[j] = 16'd160;
      run_window(sc, 8'h07, 8'd5, 0, 1'b0, 1'b0, sr);
      for (int j = 0; j < WIN; j++) sc[j] = 16'd400;
      run_window(sc, 8'h07, 8'd5, -1, 1'b0, 1'b0, sr);
      check("pre_rst_req", 32'(sr), 1);
      #2 rst = 1'b1;
      #1;
      check("midrc_req", 32'(bus.reconfig_req_o), 0);
      check("midrc_lb", 32'(bus.interval_lb_o), 0);
      check("midrc_ub", 32'(bus.interval_ub_o), 32'hFFFF);
      check("midrc_mode", 32'(bus.mode_o), 0);
      check("midrc_stall", 32'(bus.stall_o), 0);
      @(posedge clk); #1 rst = 1'b0;
      model_reset();

      // Randomized windows against the reference model.
      do_reset();
      for (int w = 0; w < 60; w++) begin
         for (int j = 0; j < WIN; j++)
            sc[j] = 16'($urandom_range(0, 65535) >> $urandom_range(0, 10));
         mask = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
         pc = 0;
         for (int j = 0; j < WIN; j++) pc += int'(mask[j]);
         run_window(sc, mask, ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'(WIN - pc),
                    $urandom_range(0, 4), 1'b1, 1'($urandom_range(0, 1)), sr);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
